ami_w: RTL



---
 rtl/ami_pkg.sv | 11 +
 rtl/ami_fifo.sv | 38 +++
 rtl/ami_w.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ami_pkg.sv
// ami_pkg: shared FSM states, AXI constants and size helper for the ami_w write engine
package ami_pkg;
  typedef enum logic [2:0] {IDLE, CALC, AW, DATA, RESP} state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int BOUNDARY_4K = 4096;
  function automatic int log2_size(input int bytes);
    for (int n = 0; n < 31; n++) if ((1 << n) >= bytes) return n;
    return 31;
  endfunction
endpackage

// File: rtl/ami_fifo.sv
// ami_fifo: show-ahead synchronous FIFO buffering prefetched SPRAM beats for the W channel
module ami_fifo
  import ami_pkg::*;
#(
  parameter int DW    = 128,
  parameter int DEPTH = 8
) (
  input  logic                     RAM_CLK,
  input  logic                     RAM_RESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout  = mem[rp];
  assign empty = count == '0;
  assign full  = count == (PW+1)'(DEPTH);
  always_ff @(posedge RAM_CLK or negedge RAM_RESETn)
    if (!RAM_RESETn) begin
      mem   <= '{default: '0};
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/ami_w.sv
// ami_w: AXI4 write master copying SPRAM words into 4KB-safe INCR bursts; AMI_ERR_ABORT_EN stops after the first error response
module ami_w
  import ami_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AMI_ID     = 0,
  parameter int AMI_MAXLEN = 16,
  parameter int AMI_WD     = 8,
  parameter int SLV_WS     = 1,
  parameter int CMD_BW     = 16,
  localparam int AXI_BYTES = AXI_DW / 8
) (
  input  logic                 RAM_CLK,
  input  logic                 RAM_RESETn,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [AXI_AW-1:0]    CMD_AXI_ADDR,
  input  logic [AXI_AW-1:0]    CMD_RAM_ADDR,
  input  logic [CMD_BW-1:0]    CMD_BEATS,
  output logic                 DONE,
  output logic                 DONE_ERR,
  output logic                 RAM_CEN,
  output logic [AXI_AW-1:0]    RAM_A,
  input  logic [AXI_DW-1:0]    RAM_Q,
  output logic [AXI_IW-1:0]    AWID,
  output logic [AXI_AW-1:0]    AWADDR,
  output logic [AXI_LW-1:0]    AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [AXI_DW-1:0]    WDATA,
  output logic [AXI_BYTES-1:0] WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [AXI_IW-1:0]    BID,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY
);
  localparam int SZ = log2_size(AXI_BYTES);
  localparam int CW = $clog2(AMI_WD) + 1;
  localparam int OW = $clog2(AMI_WD + SLV_WS) + 1;
  state_t state;
  logic [AXI_AW-1:0] addr, ram_addr;
  logic [CMD_BW-1:0] rem, blen, issued, wcnt, lim, blen_c, m1;
  logic [12:0] b4k;
  logic [AXI_LW-1:0] awlen;
  logic [SLV_WS-1:0] vld;
  logic [CW-1:0] cnt;
  logic [OW-1:0] occ;
  logic empty, full, rd_en, w_hs, err, err_n, done, done_err, unused_bid;
  always_comb begin
    b4k    = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> SZ;
    m1     = rem < CMD_BW'(AMI_MAXLEN) ? rem : CMD_BW'(AMI_MAXLEN);
    blen_c = m1 < CMD_BW'(b4k) ? m1 : CMD_BW'(b4k);
    lim    = state == CALC ? blen_c : blen;
    occ    = OW'(cnt) + OW'($countones(vld));
    rd_en  = (state == CALC || state == AW || state == DATA) && issued < lim &&
             occ < OW'(AMI_WD) && !full;
    w_hs   = WVALID && WREADY;
    err_n  = err || BRESP != RESP_OKAY;
  end
  assign CMD_READY  = state == IDLE;
  assign AWVALID    = state == AW;
  assign BREADY     = state == RESP;
  assign WVALID     = state == DATA && !empty;
  assign WLAST      = WVALID && wcnt == blen - 1'b1;
  assign AWADDR     = addr;
  assign AWLEN      = awlen;
  assign AWID       = AXI_IW'(AMI_ID);
  assign AWSIZE     = 3'(SZ);
  assign AWBURST    = BURST_INCR;
  assign WSTRB      = '1;
  assign RAM_CEN    = !rd_en;
  assign RAM_A      = ram_addr;
  assign DONE       = done;
  assign DONE_ERR   = done_err;
  assign unused_bid = ^BID;
  ami_fifo #(.DW(AXI_DW), .DEPTH(AMI_WD)) u_fifo (
    .RAM_CLK   (RAM_CLK),
    .RAM_RESETn(RAM_RESETn),
    .push      (vld[SLV_WS-1]),
    .pop       (w_hs),
    .din       (RAM_Q),
    .dout      (WDATA),
    .count     (cnt),
    .empty     (empty),
    .full      (full)
  );
  always_ff @(posedge RAM_CLK or negedge RAM_RESETn)
    if (!RAM_RESETn) begin
      state    <= IDLE;
      addr     <= '0;
      ram_addr <= '0;
      rem      <= '0;
      blen     <= '0;
      issued   <= '0;
      wcnt     <= '0;
      awlen    <= '0;
      vld      <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld[0] <= rd_en;
      for (int i = 1; i < SLV_WS; i++) vld[i] <= vld[i-1];
      if (rd_en) begin
        ram_addr <= ram_addr + 1'b1;
        issued   <= issued + 1'b1;
      end
      case (state)
        IDLE: if (CMD_VALID) begin
          addr     <= CMD_AXI_ADDR;
          ram_addr <= CMD_RAM_ADDR;
          rem      <= CMD_BEATS;
          err      <= 1'b0;
          issued   <= '0;
          state    <= CMD_BEATS == '0 ? IDLE : CALC;
          if (CMD_BEATS == '0) begin
            done     <= 1'b1;
            done_err <= 1'b0;
          end
        end
        CALC: begin
          blen  <= blen_c;
          awlen <= AXI_LW'(blen_c - 1'b1);
          wcnt  <= '0;
          state <= AW;
        end
        AW: if (AWREADY) state <= DATA;
        DATA: if (w_hs) begin
          wcnt <= wcnt + 1'b1;
          if (WLAST) state <= RESP;
        end
        RESP: if (BVALID) begin
          err    <= err_n;
          addr   <= addr + (AXI_AW'(blen) << SZ);
          rem    <= rem - blen;
          issued <= '0;
`ifdef AMI_ERR_ABORT_EN
          if (rem == blen || BRESP != RESP_OKAY) begin
`else
          if (rem == blen) begin
`endif
            state    <= IDLE;
            done     <= 1'b1;
            done_err <= err_n;
          end else state <= CALC;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
